// File: rtl/bit_population_counter_pkg.sv
// Shared definitions for the pipelined popcount engine.
//   count_mode_e   : per-beat selection between counting ones and zeros
//   stage_side_t   : sideband record carried alongside data through each stage
//   leaf_popcount  : combinational popcount of one leaf (zero-extended input)
//   pipe_latency   : accept-edge-to-valid latency for a given WIDTH/LEAF_W
package bit_population_counter_pkg;

  // Widest leaf the helper can count; callers zero-extend narrower leaves.
  localparam int MAX_LEAF_W = 32;

  typedef enum logic {
    COUNT_ONES  = 1'b0,
    COUNT_ZEROS = 1'b1
  } count_mode_e;

  typedef struct packed {
    logic        valid;
    logic        last;
    count_mode_e mode;
  } stage_side_t;

  function automatic int unsigned leaf_popcount(input logic [MAX_LEAF_W-1:0] leaf);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_LEAF_W; i++) begin
      cnt = cnt + 32'(leaf[i]);
    end
    return cnt;
  endfunction

  // Leaf stage + one stage per adder level + accumulator/output stage.
  function automatic int unsigned pipe_latency(input int unsigned width,
                                               input int unsigned leaf_w);
    return unsigned'($clog2(width / leaf_w)) + 32'd2;
  endfunction

endpackage

// File: rtl/bit_population_counter_pipe_popcount_tree_level.sv
// One registered level of the popcount adder tree.
// Adds adjacent pairs of N_IN counts of IN_W bits into N_IN/2 counts of
// IN_W+1 bits and delays the sideband by the same single cycle.
//   clk, rst_n_i          : clock, asynchronous active-low reset
//   en_i                  : pipeline advance; the level holds when low
//   valid_i/last_i/mode_i : sideband entering the level
//   sum_i                 : packed input counts, count j at [j*IN_W +: IN_W]
//   valid_o/last_o/mode_o : registered sideband
//   sum_o                 : packed registered pairwise sums
module popcount_tree_level #(
  parameter int N_IN = 8,
  parameter int IN_W = 3
) (
  input  logic                             clk,
  input  logic                             rst_n_i,
  input  logic                             en_i,
  input  logic                             valid_i,
  input  logic                             last_i,
  input  logic                             mode_i,
  input  logic [N_IN*IN_W-1:0]             sum_i,
  output logic                             valid_o,
  output logic                             last_o,
  output logic                             mode_o,
  output logic [(N_IN/2)*(IN_W+1)-1:0]     sum_o
);

  localparam int N_OUT = N_IN / 2;
  localparam int OUT_W = IN_W + 1;

  logic [N_OUT*OUT_W-1:0] sum_d, sum_q;
  logic                   valid_q, last_q, mode_q;

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    sum_d = '0;
    for (int j = 0; j < N_OUT; j++) begin
      sum_d[j*OUT_W +: OUT_W] = OUT_W'(sum_i[(2*j)*IN_W +: IN_W])
                              + OUT_W'(sum_i[(2*j+1)*IN_W +: IN_W]);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else if (en_i) begin
      sum_q   <= sum_d;
      valid_q <= valid_i;
      last_q  <= last_i;
      mode_q  <= mode_i;
    end
  end

  assign sum_o   = sum_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign mode_o  = mode_q;

endmodule

// File: rtl/bit_population_counter_pipe.sv
// Pipelined popcount engine on a valid/ready stream.
// Each beat is optionally inverted (count zeros), split into LEAF_W-bit
// leaves whose counts are registered, reduced through a registered adder
// tree, and finally added to a saturating per-frame running sum.
//   clk, rst_n_i                   : clock, asynchronous active-low reset
//   data_i, mode_i, last_i         : input beat, count mode, end-of-frame
//   data_val_i / ready_o           : input handshake
//   data_o                         : popcount of the beat
//   sum_o, ovf_o                   : frame running sum, saturation flag
//   last_o                         : beat closes its frame
//   data_val_o / ready_i           : output handshake
module bit_population_counter_pipe
  import bit_population_counter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LEAF_W = 4,
  parameter int SUM_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     mode_i,
  input  logic                     last_i,
  input  logic                     data_val_i,
  output logic                     ready_o,
  output logic [$clog2(WIDTH):0]   data_o,
  output logic [SUM_W-1:0]         sum_o,
  output logic                     last_o,
  output logic                     ovf_o,
  output logic                     data_val_o,
  input  logic                     ready_i
);

  localparam int N_LEAF  = WIDTH / LEAF_W;
  localparam int N_LVL   = $clog2(N_LEAF);
  localparam int LEAF_CW = $clog2(LEAF_W + 1);
  localparam int TREE_W  = LEAF_CW + N_LVL;
  localparam int OUT_W   = $clog2(WIDTH) + 1;
  localparam logic [SUM_W-1:0] SUM_MAX = '1;

  // The whole pipeline moves together; a stalled output freezes every stage.
  logic advance;
  assign advance = !data_val_o || ready_i;
  assign ready_o = advance;

  // ---------------- Stage 1: inversion and leaf counts ----------------
  logic [WIDTH-1:0]          beat;
  logic [N_LEAF*LEAF_CW-1:0] leaf_d, leaf_q;
  stage_side_t               side1_d, side1_q;

  assign beat = (count_mode_e'(mode_i) == COUNT_ZEROS) ? ~data_i : data_i;

  always_comb begin
    leaf_d = '0;
    for (int i = 0; i < N_LEAF; i++) begin
      leaf_d[i*LEAF_CW +: LEAF_CW] =
        LEAF_CW'(leaf_popcount(MAX_LEAF_W'(beat[i*LEAF_W +: LEAF_W])));
    end
  end

  // Sideband of a bubble is forced inert so stale last/mode never travel.
  assign side1_d.valid = data_val_i;
  assign side1_d.last  = data_val_i & last_i;
  assign side1_d.mode  = data_val_i ? count_mode_e'(mode_i) : COUNT_ONES;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      leaf_q  <= '0;
      side1_q <= '0;
    end else if (advance) begin
      leaf_q  <= leaf_d;
      side1_q <= side1_d;
    end
  end

  // ---------------- Stages 2..N_LVL+1: adder tree ----------------
  for (genvar k = 0; k < N_LVL; k++) begin : g_lvl
    localparam int N_IN = N_LEAF >> k;
    localparam int IN_W = LEAF_CW + k;

    logic [N_IN*IN_W-1:0]         sum_in;
    logic                         valid_in, last_in, mode_in;
    logic [(N_IN/2)*(IN_W+1)-1:0] sum_out;
    logic                         valid_out, last_out, mode_out;

    if (k == 0) begin : g_first
      assign sum_in   = leaf_q;
      assign valid_in = side1_q.valid;
      assign last_in  = side1_q.last;
      assign mode_in  = side1_q.mode;
    end else begin : g_next
      assign sum_in   = g_lvl[k-1].sum_out;
      assign valid_in = g_lvl[k-1].valid_out;
      assign last_in  = g_lvl[k-1].last_out;
      assign mode_in  = g_lvl[k-1].mode_out;
    end

    popcount_tree_level #(
      .N_IN (N_IN),
      .IN_W (IN_W)
    ) u_level (
      .clk     (clk),
      .rst_n_i (rst_n_i),
      .en_i    (advance),
      .valid_i (valid_in),
      .last_i  (last_in),
      .mode_i  (mode_in),
      .sum_i   (sum_in),
      .valid_o (valid_out),
      .last_o  (last_out),
      .mode_o  (mode_out),
      .sum_o   (sum_out)
    );
  end

  logic [TREE_W-1:0] tree_sum;
  logic              tail_valid, tail_last, unused_tail_mode;

  assign tree_sum         = g_lvl[N_LVL-1].sum_out;
  assign tail_valid       = g_lvl[N_LVL-1].valid_out;
  assign tail_last        = g_lvl[N_LVL-1].last_out;
  assign unused_tail_mode = g_lvl[N_LVL-1].mode_out;

  // ---------------- Final stage: accumulator and outputs ----------------
  logic [OUT_W-1:0] beat_cnt;
  logic [SUM_W-1:0] acc;
  logic             frame_ovf, sat;
  logic [SUM_W:0]   total;

  logic             data_val_d, data_val_q;
  logic [OUT_W-1:0] data_d, data_q;
  logic [SUM_W-1:0] sum_d, sum_q;
  logic             last_d, last_q;
  logic             ovf_d, ovf_q;

  assign beat_cnt = OUT_W'(tree_sum);

  // The previous output already holds the frame's running sum; a last beat
  // on the output register means the next beat opens a fresh frame.
  assign acc       = last_q ? '0 : sum_q;
  assign frame_ovf = ovf_q && !last_q;
  assign total     = {1'b0, acc} + (SUM_W+1)'(beat_cnt);
  assign sat       = frame_ovf || total[SUM_W];

  always_comb begin
    data_val_d = data_val_q;
    data_d     = data_q;
    sum_d      = sum_q;
    last_d     = last_q;
    ovf_d      = ovf_q;
    if (advance) begin
      data_val_d = tail_valid;
      // Bubbles leave the result registers, and therefore acc, untouched.
      if (tail_valid) begin
        data_d = beat_cnt;
        sum_d  = sat ? SUM_MAX : total[SUM_W-1:0];
        last_d = tail_last;
        ovf_d  = sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_val_q <= 1'b0;
      data_q     <= '0;
      sum_q      <= '0;
      last_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      data_val_q <= data_val_d;
      data_q     <= data_d;
      sum_q      <= sum_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
    end
  end

  assign data_val_o = data_val_q;
  assign data_o     = data_q;
  assign sum_o      = sum_q;
  assign last_o     = last_q;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_bit_population_counter_pipe.sv
// Scoreboard bench: the driver pushes the expected result of every accepted
// beat; an independent monitor pops and compares on each output transfer.
// Two instances share the stimulus: default SUM_W and a narrow SUM_W=6 one
// whose running sum saturates quickly.
module tb_bit_population_counter_pipe;
  import bit_population_counter_pkg::*;

  localparam int WIDTH   = 32;
  localparam int LEAF_W  = 4;
  localparam int SUM_W   = 16;
  localparam int SUM_W_B = 6;
  localparam int OUT_W   = $clog2(WIDTH) + 1;
  localparam int MAX_A   = (1 << SUM_W) - 1;
  localparam int MAX_B   = (1 << SUM_W_B) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [WIDTH-1:0] data_i;
  logic             mode_i, last_i, data_val_i, ready_i;

  logic             ready_a, val_a, last_a, ovf_a;
  logic [OUT_W-1:0] data_a;
  logic [SUM_W-1:0] sum_a;
  logic             ready_b, val_b, last_b, ovf_b;
  logic [OUT_W-1:0] data_b;
  logic [SUM_W_B-1:0] sum_b;

  bit_population_counter_pipe #(.WIDTH(WIDTH), .LEAF_W(LEAF_W), .SUM_W(SUM_W)) u_dut (
    .clk(clk), .rst_n_i(rst_n), .data_i(data_i), .mode_i(mode_i), .last_i(last_i),
    .data_val_i(data_val_i), .ready_o(ready_a), .data_o(data_a), .sum_o(sum_a),
    .last_o(last_a), .ovf_o(ovf_a), .data_val_o(val_a), .ready_i(ready_i)
  );

  bit_population_counter_pipe #(.WIDTH(WIDTH), .LEAF_W(LEAF_W), .SUM_W(SUM_W_B)) u_dut_sat (
    .clk(clk), .rst_n_i(rst_n), .data_i(data_i), .mode_i(mode_i), .last_i(last_i),
    .data_val_i(data_val_i), .ready_o(ready_b), .data_o(data_b), .sum_o(sum_b),
    .last_o(last_b), .ovf_o(ovf_b), .data_val_o(val_b), .ready_i(ready_i)
  );

  typedef struct {
    int   data;
    int   sum;
    logic last;
    logic ovf;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   frame_total;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame total is kept unbounded and clipped to each
  // instance's range; a total beyond the range means saturation for the rest
  // of the frame because the total never decreases within a frame.
  task automatic push_expected(input logic [WIDTH-1:0] d, input logic m, input logic l);
    exp_t ea, eb;
    int   cnt;
    cnt = m ? WIDTH - $countones(d) : $countones(d);
    frame_total += cnt;
    ea.data = cnt;
    ea.sum  = (frame_total > MAX_A) ? MAX_A : frame_total;
    ea.ovf  = (frame_total > MAX_A);
    ea.last = l;
    eb.data = cnt;
    eb.sum  = (frame_total > MAX_B) ? MAX_B : frame_total;
    eb.ovf  = (frame_total > MAX_B);
    eb.last = l;
    qa.push_back(ea);
    qb.push_back(eb);
    if (l) frame_total = 0;
  endtask

  // Inputs change 1 time unit after a rising edge; ready_o is sampled on the
  // falling edge, so acceptance at the next rising edge is known in advance.
  task automatic drive(input logic [WIDTH-1:0] d, input logic m, input logic l,
                       input logic v, output logic accepted);
    data_i     = d;
    mode_i     = m;
    last_i     = l;
    data_val_i = v;
    @(negedge clk);
    accepted = v && ready_a;
    if (accepted) push_expected(d, m, l);
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] d, input logic m, input logic l);
    logic acc;
    int   tries;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 50) begin
      drive(d, m, l, 1'b1, acc);
      tries++;
    end
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  // ---------------- Monitor ----------------
  logic        hold_a = 1'b0, hold_b = 1'b0;
  logic [24:0] saved_a;
  logic [14:0] saved_b;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_a = 1'b0;
      hold_b = 1'b0;
    end else begin
      // A stalled output must not move until it is taken.
      if (hold_a) check("hold_a", {val_a, data_a, sum_a, last_a, ovf_a}, saved_a);
      if (hold_b) check("hold_b", {val_b, data_b, sum_b, last_b, ovf_b}, saved_b);

      if (val_a && ready_i) begin
        if (qa.size() == 0) check("spurious_a", 1, 0);
        else begin
          e = qa.pop_front();
          check("data_a", data_a, e.data);
          check("sum_a",  sum_a,  e.sum);
          check("last_a", last_a, e.last);
          check("ovf_a",  ovf_a,  e.ovf);
        end
      end
      if (val_b && ready_i) begin
        if (qb.size() == 0) check("spurious_b", 1, 0);
        else begin
          e = qb.pop_front();
          check("data_b", data_b, e.data);
          check("sum_b",  sum_b,  e.sum);
          check("last_b", last_b, e.last);
          check("ovf_b",  ovf_b,  e.ovf);
        end
      end

      hold_a  = val_a && !ready_i;
      hold_b  = val_b && !ready_i;
      saved_a = {val_a, data_a, sum_a, last_a, ovf_a};
      saved_b = {val_b, data_b, sum_b, last_b, ovf_b};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- Stimulus ----------------
  initial begin
    logic acc;
    int   cnt;
    logic [WIDTH-1:0] d;

    rst_n       = 1'b0;
    data_i      = '0;
    mode_i      = 1'b0;
    last_i      = 1'b0;
    data_val_i  = 1'b0;
    ready_i     = 1'b1;
    frame_total = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_val_a", val_a, 0);
    check("rst_out_a", {data_a, sum_a, last_a, ovf_a}, 0);
    check("rst_val_b", val_b, 0);
    check("rst_out_b", {data_b, sum_b, last_b, ovf_b}, 0);
    rst_n = 1'b1;
    idle(2);

    // Latency: count rising edges, accept edge included, until valid shows.
    drive(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, acc);
    check("lat_accept", acc, 1);
    cnt = 1;
    while (!val_a && cnt < 20) begin
      drive('0, 1'b0, 1'b0, 1'b0, acc);
      cnt++;
    end
    check("latency", cnt, pipe_latency(WIDTH, LEAF_W));
    idle(2);

    // Counting zeros, then a short multi-beat frame.
    send_beat(32'h0000_000F, 1'b1, 1'b1);
    send_beat(32'h1, 1'b0, 1'b0);
    send_beat(32'h3, 1'b0, 1'b0);
    send_beat(32'h7, 1'b0, 1'b1);
    send_beat(32'h1, 1'b0, 1'b1);
    send_beat(32'h0, 1'b0, 1'b1);
    idle(8);

    // Ten-beat stream with a three-cycle output stall in the middle.
    for (int i = 0; i < 7; i++) send_beat(32'h0101_0101 * (i + 1), 1'b0, 1'b0);
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'hA5A5_0007, 1'b0, 1'b0, 1'b1, acc);
      check("stall_ready_o", acc, 0);
    end
    ready_i = 1'b1;
    send_beat(32'hA5A5_0007, 1'b0, 1'b0);
    send_beat(32'h8000_0001, 1'b1, 1'b0);
    send_beat(32'hFFFF_0000, 1'b0, 1'b1);
    idle(8);

    // Three all-ones beats, then a fresh frame.
    send_beat(32'hFFFF_FFFF, 1'b0, 1'b0);
    send_beat(32'hFFFF_FFFF, 1'b0, 1'b0);
    send_beat(32'hFFFF_FFFF, 1'b0, 1'b1);
    send_beat(32'h0000_0001, 1'b0, 1'b1);

    // Long all-ones frame crossing the default instance's saturation point.
    for (int i = 0; i < 2050; i++) send_beat(32'hFFFF_FFFF, 1'b0, i == 2049);
    send_beat(32'h0000_00FF, 1'b0, 1'b1);
    idle(8);

    // Randomised traffic with bubbles and random backpressure.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0:       d = '0;
        1:       d = '1;
        default: d = $urandom;
      endcase
      ready_i = ($urandom_range(0, 3) != 0);
      drive(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) != 0), acc);
    end
    ready_i = 1'b1;
    idle(10);

    // Reset with beats in flight in the middle of a frame.
    for (int i = 0; i < 4; i++) send_beat(32'h0F0F_0F0F, 1'b0, 1'b0);
    rst_n      = 1'b0;
    data_val_i = 1'b0;
    #1;
    check("midrst_val_a", val_a, 0);
    check("midrst_out_a", {data_a, sum_a, last_a, ovf_a}, 0);
    check("midrst_val_b", val_b, 0);
    check("midrst_out_b", {data_b, sum_b, last_b, ovf_b}, 0);
    qa.delete();
    qb.delete();
    frame_total = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_beat(32'h0000_0003, 1'b0, 1'b0);
    send_beat(32'h0000_00FF, 1'b0, 1'b1);

    // Drain and confirm every expected result was seen.
    cnt = 0;
    while ((qa.size() != 0 || qb.size() != 0) && cnt < 100) begin
      idle(1);
      cnt++;
    end
    idle(2);
    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
